multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Sequencing FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
//  Drives datapath mux selects, register/PC/IR write strobes and a req/ready memory handshake.
//  Sits between the instruction register (opcode, ALU zero flag) and the shared datapath and memory.
//  ALU function is resolved downstream from alu_op by the existing ALU decoder.
// PARAMETERS
//  MEM_TIMEOUT  255  max consecutive cycles mem_req may stay unacknowledged; 0 disables the timeout.
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  opcode       in   7  instr[6:0] from the IR; stable from DECODE until the next FETCH
//  zero         in   1  ALU zero flag
//  mem_ready    in   1  memory acknowledges mem_req this cycle
//  mem_req      out  1  memory access request
//  mem_write    out  1  store qualifier, valid while mem_req=1
//  adr_src      out  1  address mux: 0 = PC, 1 = ALUOut
//  ir_write     out  1  IR/OldPC load strobe
//  pc_write     out  1  PC load strobe = pc_update | (branch & zero)
//  reg_write    out  1  register file write strobe
//  alu_src_a    out  2  00 = PC, 01 = OldPC, 10 = rs1
//  alu_src_b    out  2  00 = rs2, 01 = imm, 10 = const 4
//  alu_op       out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
//  result_src   out  2  00 = ALUOut, 01 = read data, 10 = ALUResult
//  imm_src      out  2  immediate format: lw/I = 00, sw = 01, beq = 10, jal = 11, else 00
//  trap         out  1  sticky fault: illegal opcode or memory timeout
// BEHAVIOUR
//  - Reset: state = FETCH, wait counter = 0, trap = 0. Strobes (mem_req, mem_write, ir_write,
//    pc_write, reg_write) are gated low while rst = 1. First request is issued the cycle after
//    rst deasserts.
//  - Outputs are Moore, decoded from state. Exceptions: pc_write (combinational on zero),
//    imm_src (combinational on opcode), and the ready-qualified strobes below.
//  - FETCH: mem_req = 1, adr_src = 0, srcA = 00, srcB = 10, alu_op = 00, result_src = 10.
//    On mem_ready: ir_write = 1, pc_update = 1, go to DECODE. Otherwise hold.
//  - DECODE: srcA = 01, srcB = 01, alu_op = 00 (branch/jump target precompute). Next state:
//    lw/sw -> MEMADR; R -> EXECR; I -> EXECI; beq -> BEQ; jal -> JAL; any other -> TRAP.
//  - MEMADR: srcA = 10, srcB = 01, alu_op = 00. lw -> MEMREAD, sw -> MEMWRITE.
//  - MEMREAD: mem_req = 1, adr_src = 1. On mem_ready -> MEMWB.
//  - MEMWB: result_src = 01, reg_write = 1, -> FETCH.
//  - MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1, held until mem_ready; then -> FETCH.
//  - EXECR: srcA = 10, srcB = 00, alu_op = 10, -> ALUWB.
//  - EXECI: srcA = 10, srcB = 01, alu_op = 10, -> ALUWB.
//  - ALUWB: result_src = 00, reg_write = 1, -> FETCH.
//  - BEQ: srcA = 10, srcB = 00, alu_op = 01, result_src = 00, branch = 1, -> FETCH.
//  - JAL: srcA = 01, srcB = 10, alu_op = 00, result_src = 00, pc_update = 1, -> ALUWB (rd = PC+4).
//  - TRAP: absorbing. All strobes 0, trap = 1. Left only via rst.
//  - Unlisted selects are driven to 0 (never X).
//  - Latency (zero-wait memory): lw 5 cycles, sw 4, R/I 4, jal 4, beq 3.
//  - Wait counter:
//    - Increments each cycle with mem_req & !mem_ready; clears on mem_ready or state change.
//    - When MEM_TIMEOUT != 0 and the count reaches MEM_TIMEOUT, the next state is TRAP.
//    - mem_ready in that same cycle takes priority: the access completes normally.
//  - rst asserted mid-access aborts it immediately (async). Memory must drop the pending request.
// STRUCTURE
//  - Package rv_ctrl_pkg: state_t enum; opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ,
//    OP_JAL); select encodings for alu_src_a, alu_src_b, result_src, alu_op, imm_src.
//  - One sub-module: mem_wait_timer (counter + timeout compare, parameterised by MEM_TIMEOUT).
//  - Everything else stays in this module: a state register plus next-state and output always_comb.
// TESTING
//  1. rst pulse, lw (0000011), mem_ready = 1 always -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB;
//     reg_write = 1 only in MEMWB with result_src = 01.
//  2. sw (0100011), mem_ready low 3 cycles in MEMWRITE -> mem_write = 1 for 4 cycles,
//     reg_write never 1, back to FETCH.
//  3. beq with zero = 1 -> pc_write = 1 in BEQ; with zero = 0 -> pc_write = 0. 3 cycles each.
//  4. jal (1101111) -> pc_write = 1 in JAL; then ALUWB with reg_write = 1, result_src = 00;
//     imm_src = 11 throughout.
//  5. opcode 1111111 -> TRAP: trap = 1, all strobes 0 for 10+ cycles; rst -> FETCH, trap = 0.
//  6. MEM_TIMEOUT = 4, mem_ready = 0 in FETCH -> TRAP after 4 wait cycles.
//     Separately, rst mid-MEMREAD -> FETCH, mem_req = 0 during reset.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I controller.
// Covers the state enum, opcode constants, datapath select codes and the immediate-format helper.
`timescale 1ns/1ps
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive unacknowledged memory-request cycles and flags a timeout.
// A count of MEM_TIMEOUT with the request still pending raises timeout; MEM_TIMEOUT = 0 disables it.
`timescale 1ns/1ps
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic clear,
  output logic timeout
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [CW-1:0] count_reg, count_next;

  // Saturates instead of wrapping so a disabled timer cannot alias back to zero.
  always_comb begin
    count_next = count_reg;
    if (clear)
      count_next = '0;
    else if (waiting && (count_reg != {CW{1'b1}}))
      count_next = count_reg + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_reg <= '0;
    else     count_reg <= count_next;
  end

  generate
    if (MEM_TIMEOUT == 0) begin : g_no_timeout
      assign timeout = 1'b0;
    end else begin : g_timeout
      assign timeout = waiting && (count_reg == CW'(MEM_TIMEOUT));
    end
  endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle RV32I core: datapath selects, write strobes and memory handshake.
// Moore outputs from state, except the ready-qualified strobes, pc_write (zero) and imm_src (opcode).
`timescale 1ns/1ps
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       trap
);

  state_t state_reg, state_next;
  logic   req_c, write_c, irw_c, pc_update, branch, regw_c, timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_c      = 1'b0;
    write_c    = 1'b0;
    irw_c      = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    regw_c     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    result_src = RES_ALUOUT;
    case (state_reg)
      FETCH: begin
        req_c      = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_ready) begin
          irw_c      = 1'b1;
          pc_update  = 1'b1;
          state_next = DECODE;
        end else if (timeout) begin
          state_next = TRAP;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        req_c   = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)    state_next = MEMWB;
        else if (timeout) state_next = TRAP;
      end
      MEMWB: begin
        result_src = RES_RDATA;
        regw_c     = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        req_c   = 1'b1;
        write_c = 1'b1;
        adr_src = 1'b1;
        if (mem_ready)    state_next = FETCH;
        else if (timeout) state_next = TRAP;
      end
      EXECR: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        regw_c     = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      TRAP:    state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .waiting (req_c & ~mem_ready),
    .clear   (mem_ready | (state_next != state_reg)),
    .timeout (timeout)
  );

  // Strobes are forced low during reset so a held FETCH state cannot issue a request.
  assign mem_req   = req_c   & ~rst;
  assign mem_write = write_c & ~rst;
  assign ir_write  = irw_c   & ~rst;
  assign reg_write = regw_c  & ~rst;
  assign pc_write  = (pc_update | (branch & zero)) & ~rst;
  assign imm_src   = imm_sel(opcode);
  assign trap      = (state_reg == TRAP);

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven check of the multicycle controller with a queue scoreboard per cycle.
// Hand sequences cover timeout boundary, reset mid-access, timeout trap and illegal-opcode trap.
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [6:0] opcode;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src), .trap(trap)
  );

  typedef struct packed {
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
  } outs_t;

  typedef struct {
    logic [6:0] op;
    logic       z;
    logic       rdy;
    outs_t      exp;
    string      tag;
  } vec_t;

  outs_t exp_q[$];
  string tag_q[$];
  vec_t  tbl[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  function automatic outs_t o(input logic mr, mw, as, irw, pcw, rw, tr,
                              input logic [1:0] sa, sb, op, rs, imm);
    outs_t r;
    r.mem_req = mr; r.mem_write = mw; r.adr_src = as; r.ir_write = irw;
    r.pc_write = pcw; r.reg_write = rw; r.trap = tr;
    r.alu_src_a = sa; r.alu_src_b = sb; r.alu_op = op; r.result_src = rs; r.imm_src = imm;
    return r;
  endfunction

  function automatic outs_t fetch(input logic rdy, input logic [1:0] imm);
    return o(1, 0, 0, rdy, rdy, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, imm);
  endfunction
  function automatic outs_t dec(input logic [1:0] imm);
    return o(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 2'b00, imm);
  endfunction
  function automatic outs_t memadr(input logic [1:0] imm);
    return o(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, imm);
  endfunction
  function automatic outs_t aluwb(input logic [1:0] imm);
    return o(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm);
  endfunction
  function automatic outs_t rstv(input logic [1:0] imm);
    return o(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, imm);
  endfunction
  function automatic outs_t trapv(input logic [1:0] imm);
    return o(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm);
  endfunction

  function automatic vec_t mk(input logic [6:0] op, input logic z, rdy,
                              input outs_t e, input string tag);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.exp = e; v.tag = tag;
    return v;
  endfunction

  // Drive one cycle of inputs, push the expectation, compare at the falling edge.
  task automatic step(input logic [6:0] op, input logic z, input logic rdy, input logic r,
                      input outs_t e, input string tag);
    outs_t got, want;
    string t;
    opcode = op; zero = z; mem_ready = rdy; rst = r;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, trap,
           alu_src_a, alu_src_b, alu_op, result_src, imm_src};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: outputs %05h, expected %05h", t, got, want);
    end else begin
      $display("ok   %s: outputs %05h", t, got);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // lw, zero-wait memory
    tbl.push_back(mk(LW, 0, 1, fetch(1, 2'b00), "lw_fetch"));
    tbl.push_back(mk(LW, 0, 1, dec(2'b00), "lw_decode"));
    tbl.push_back(mk(LW, 0, 1, memadr(2'b00), "lw_memadr"));
    tbl.push_back(mk(LW, 0, 1, o(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b00), "lw_memread"));
    tbl.push_back(mk(LW, 0, 1, o(0,0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b01, 2'b00), "lw_memwb"));
    // sw with three wait cycles
    tbl.push_back(mk(SW, 0, 1, fetch(1, 2'b01), "sw_fetch"));
    tbl.push_back(mk(SW, 0, 1, dec(2'b01), "sw_decode"));
    tbl.push_back(mk(SW, 0, 1, memadr(2'b01), "sw_memadr"));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(SW, 0, 0, o(1,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b01), "sw_memwrite_wait"));
    tbl.push_back(mk(SW, 0, 1, o(1,1,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b01), "sw_memwrite_done"));
    // beq taken, then not taken
    tbl.push_back(mk(BQ, 1, 1, fetch(1, 2'b10), "beq1_fetch"));
    tbl.push_back(mk(BQ, 1, 1, dec(2'b10), "beq1_decode"));
    tbl.push_back(mk(BQ, 1, 1, o(0,0,0,0,1,0,0, 2'b10,2'b00,2'b01,2'b00, 2'b10), "beq1_taken"));
    tbl.push_back(mk(BQ, 0, 1, fetch(1, 2'b10), "beq0_fetch"));
    tbl.push_back(mk(BQ, 0, 1, dec(2'b10), "beq0_decode"));
    tbl.push_back(mk(BQ, 0, 1, o(0,0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 2'b10), "beq0_not_taken"));
    // jal
    tbl.push_back(mk(JL, 0, 1, fetch(1, 2'b11), "jal_fetch"));
    tbl.push_back(mk(JL, 0, 1, dec(2'b11), "jal_decode"));
    tbl.push_back(mk(JL, 0, 1, o(0,0,0,0,1,0,0, 2'b01,2'b10,2'b00,2'b00, 2'b11), "jal_jal"));
    tbl.push_back(mk(JL, 0, 1, aluwb(2'b11), "jal_aluwb"));
    // R-type and I-type ALU
    tbl.push_back(mk(RT, 1, 1, fetch(1, 2'b00), "r_fetch"));
    tbl.push_back(mk(RT, 1, 1, dec(2'b00), "r_decode"));
    tbl.push_back(mk(RT, 1, 1, o(0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 2'b00), "r_execr"));
    tbl.push_back(mk(RT, 1, 1, aluwb(2'b00), "r_aluwb"));
    tbl.push_back(mk(IT, 0, 1, fetch(1, 2'b00), "i_fetch"));
    tbl.push_back(mk(IT, 0, 1, dec(2'b00), "i_decode"));
    tbl.push_back(mk(IT, 0, 1, o(0,0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 2'b00), "i_execi"));
    tbl.push_back(mk(IT, 0, 1, aluwb(2'b00), "i_aluwb"));

    rst = 1'b1; opcode = LW; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(LW, 0, 1, 1, rstv(2'b00), "reset_state");

    foreach (tbl[i]) step(tbl[i].op, tbl[i].z, tbl[i].rdy, 0, tbl[i].exp, tbl[i].tag);

    // Ready arriving on the last permitted wait cycle completes the fetch
    for (int i = 0; i < 4; i++) step(RT, 0, 0, 0, fetch(0, 2'b00), "fetch_wait");
    step(RT, 0, 1, 0, fetch(1, 2'b00), "fetch_ready_at_limit");
    step(RT, 0, 1, 0, dec(2'b00), "decode_after_limit");
    step(RT, 0, 1, 0, o(0,0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 2'b00), "execr_after_limit");
    step(RT, 0, 1, 0, aluwb(2'b00), "aluwb_after_limit");

    // Reset in the middle of a load access
    step(LW, 0, 1, 0, fetch(1, 2'b00), "abort_fetch");
    step(LW, 0, 1, 0, dec(2'b00), "abort_decode");
    step(LW, 0, 1, 0, memadr(2'b00), "abort_memadr");
    for (int i = 0; i < 2; i++)
      step(LW, 0, 0, 0, o(1,0,1,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b00), "memread_wait");
    step(LW, 0, 0, 1, rstv(2'b00), "rst_mid_memread");

    // Fetch never acknowledged: four waits allowed, fifth traps
    step(LW, 0, 0, 0, fetch(0, 2'b00), "timeout_wait");
    for (int i = 0; i < 4; i++) step(LW, 0, 0, 0, fetch(0, 2'b00), "timeout_wait");
    step(LW, 0, 0, 0, trapv(2'b00), "timeout_trap");
    step(LW, 1, 1, 0, trapv(2'b00), "timeout_trap_hold");
    step(BAD, 0, 1, 1, rstv(2'b00), "rst_clears_timeout_trap");

    // Illegal opcode
    step(BAD, 0, 1, 0, fetch(1, 2'b00), "bad_fetch");
    step(BAD, 0, 1, 0, dec(2'b00), "bad_decode");
    for (int i = 0; i < 10; i++) step(BAD, i[0], 1, 0, trapv(2'b00), "bad_trap_hold");
    step(BAD, 0, 1, 1, rstv(2'b00), "rst_clears_trap");
    step(LW, 0, 1, 0, fetch(1, 2'b00), "fetch_after_trap");
    step(LW, 0, 1, 0, dec(2'b00), "decode_after_trap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
